// File: rtl/ag_o_sys_out_if.sv
// Write-port side bundle of the sys_out address generator: start request
// from the array controller, address/enable/status toward the DPR.
interface ag_o_sys_out_if #(
  parameter int FEATURE_BITS = 4
);
  logic                    start;
  logic [FEATURE_BITS-1:0] address;
  logic                    wr_en;
  logic                    busy;
  logic                    done;

  // Controller side: issues start, observes the generator.
  modport master (output start, input address, wr_en, busy, done);
  // Generator side.
  modport slave  (input start, output address, wr_en, busy, done);
endinterface

// File: rtl/ag_o_sys_out.sv
// sys_out DPR write-address generator. After a start request it waits out the
// systolic-array pipeline fill, then writes addresses 0..DEPTH-1 on
// consecutive cycles and pulses done. All outputs are registered.
module ag_o_sys_out #(
  parameter int FEATURE_BITS = 4,
  parameter int DEPTH        = 16,
  parameter int FILL_LATENCY = 4
) (
  input  logic            sys_clk,
  input  logic            reset_n,
  ag_o_sys_out_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [7:0] FILL_LOAD =
    8'((FILL_LATENCY > 0) ? (FILL_LATENCY - 1) : 0);
  // Terminal address is an explicit compare so DEPTH < 2**FEATURE_BITS ends
  // correctly and a full-range DEPTH does not rely on counter overflow.
  localparam logic [FEATURE_BITS-1:0] LAST_ADDR = FEATURE_BITS'(DEPTH - 1);

  state_t                  r_state;
  logic [7:0]              r_cnt;
  logic [FEATURE_BITS-1:0] r_addr;
  logic                    r_wr_en;
  logic                    r_busy;
  logic                    r_done;

  state_t                  w_state;
  logic [7:0]              w_cnt;
  logic [FEATURE_BITS-1:0] w_addr;
  logic                    w_wr_en;
  logic                    w_busy;
  logic                    w_done;

  // State, fill counter and registered outputs; reset clears everything.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wr_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_addr  <= w_addr;
      r_wr_en <= w_wr_en;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  // Next state plus the output values that state will present after the edge.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_addr  = '0;
    w_wr_en = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_busy = 1'b1;
          if (FILL_LATENCY == 0) begin
            w_state = S_RUN;
            w_wr_en = 1'b1;
          end else begin
            w_state = S_FILL;
            w_cnt   = FILL_LOAD;
          end
        end
      end
      S_FILL: begin
        w_busy = 1'b1;
        if (r_cnt == 8'd0) begin
          w_state = S_RUN;
          w_wr_en = 1'b1;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_RUN: begin
        if (r_addr == LAST_ADDR) begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end else begin
          w_addr  = r_addr + FEATURE_BITS'(1);
          w_wr_en = 1'b1;
          w_busy  = 1'b1;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign bus.address = r_addr;
  assign bus.wr_en   = r_wr_en;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_ag_o_sys_out.sv
// Scoreboard bench for ag_o_sys_out: three instances (default, FILL_LATENCY=0
// with DEPTH=1, DEPTH=10). Stimulus pushes the expected write/done events with
// their absolute cycle numbers; per-negedge monitors pop and compare.
module tb_ag_o_sys_out;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;

  always #5 sys_clk = ~sys_clk;

  // Absolute edge counter; events are timestamped against it.
  always @(posedge sys_clk) cyc <= cyc + 1;

  ag_o_sys_out_if #(.FEATURE_BITS(4)) if_a ();
  ag_o_sys_out_if #(.FEATURE_BITS(4)) if_b ();
  ag_o_sys_out_if #(.FEATURE_BITS(4)) if_c ();

  ag_o_sys_out #(.FEATURE_BITS(4), .DEPTH(16), .FILL_LATENCY(4)) u_a (
    .sys_clk (sys_clk), .reset_n (reset_n), .bus (if_a));
  ag_o_sys_out #(.FEATURE_BITS(4), .DEPTH(1), .FILL_LATENCY(0)) u_b (
    .sys_clk (sys_clk), .reset_n (reset_n), .bus (if_b));
  ag_o_sys_out #(.FEATURE_BITS(4), .DEPTH(10), .FILL_LATENCY(4)) u_c (
    .sys_clk (sys_clk), .reset_n (reset_n), .bus (if_c));

  typedef struct {
    int cyc;
    int addr;
    bit dn;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  ev_t qc[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  task automatic push_ev(input int id, input ev_t ev);
    case (id)
      0: qa.push_back(ev);
      1: qb.push_back(ev);
      default: qc.push_back(ev);
    endcase
  endtask

  // Start sampled at edge e: write k lands after edge e+lat+k, done after e+lat+depth.
  task automatic push_pass(input int id, input int e, input int lat, input int depth);
    ev_t ev;
    for (int k = 0; k < depth; k++) begin
      ev.cyc = e + lat + k; ev.addr = k; ev.dn = 1'b0;
      push_ev(id, ev);
    end
    ev.cyc = e + lat + depth; ev.addr = 0; ev.dn = 1'b1;
    push_ev(id, ev);
  endtask

  task automatic observe(input int id, input string tag, input logic we,
                         input logic dn, input logic bz, input int addr);
    ev_t e;
    bit  have;
    have = 1'b0;
    if (!(we || dn)) begin
      chk({tag, "_quiet_addr"}, addr, 0);
      return;
    end
    case (id)
      0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
      1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
      default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      chk({tag, "_unexpected_output"}, 1, 0);
      return;
    end
    chk({tag, "_cycle"}, cyc, e.cyc);
    chk({tag, "_addr"},  addr, e.addr);
    chk({tag, "_done"},  int'(dn), int'(e.dn));
    chk({tag, "_wr_en"}, int'(we), int'(!e.dn));
    chk({tag, "_busy"},  int'(bz), int'(!e.dn));
  endtask

  // Monitors: compare every output-bearing cycle against the scoreboard.
  always @(negedge sys_clk) begin
    if (reset_n) begin
      observe(0, "A", if_a.wr_en, if_a.done, if_a.busy, int'(if_a.address));
      observe(1, "B", if_b.wr_en, if_b.done, if_b.busy, int'(if_b.address));
      observe(2, "C", if_c.wr_en, if_c.done, if_c.busy, int'(if_c.address));
    end
  end

  task automatic chk_zero(input string tag, input logic [3:0] addr, input logic we,
                          input logic bz, input logic dn);
    chk({tag, "_address"}, int'(addr), 0);
    chk({tag, "_wr_en"},   int'(we),   0);
    chk({tag, "_busy"},    int'(bz),   0);
    chk({tag, "_done"},    int'(dn),   0);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge sys_clk);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0) break;
      @(negedge sys_clk);
    end
    chk("drain_A", qa.size(), 0);
    chk("drain_B", qb.size(), 0);
    chk("drain_C", qc.size(), 0);
    repeat (3) @(negedge sys_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  e;
    int  e2;
    bit  found;

    // Reset held with start high: everything must stay quiet.
    if_a.start = 1'b1; if_b.start = 1'b1; if_c.start = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_zero("rst_A", if_a.address, if_a.wr_en, if_a.busy, if_a.done);
    chk_zero("rst_B", if_b.address, if_b.wr_en, if_b.busy, if_b.done);
    chk_zero("rst_C", if_c.address, if_c.wr_en, if_c.busy, if_c.done);
    if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Basic pass with defaults.
    if_a.start = 1'b1;
    e = cyc + 1;
    push_pass(0, e, 4, 16);
    @(negedge sys_clk);
    if_a.start = 1'b0;
    chk("A_fill_busy",  int'(if_a.busy),  1);
    chk("A_fill_wr_en", int'(if_a.wr_en), 0);
    drain(100);

    // Start held across two passes.
    if_a.start = 1'b1;
    e  = cyc + 1;
    e2 = e + 4 + 16 + 2;
    push_pass(0, e,  4, 16);
    push_pass(0, e2, 4, 16);
    wait_to(e2 + 1);
    if_a.start = 1'b0;
    drain(100);

    // Start toggled during FILL and RUN must not disturb the pass.
    if_a.start = 1'b1;
    e = cyc + 1;
    push_pass(0, e, 4, 16);
    wait_to(e + 1);  if_a.start = 1'b0;
    wait_to(e + 2);  if_a.start = 1'b1;
    wait_to(e + 7);  if_a.start = 1'b0;
    wait_to(e + 9);  if_a.start = 1'b1;
    wait_to(e + 12); if_a.start = 1'b0;
    drain(100);

    // Mid-pass asynchronous reset at address 7, then restart.
    if_a.start = 1'b1;
    e = cyc + 1;
    push_pass(0, e, 4, 16);
    @(negedge sys_clk);
    if_a.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (if_a.wr_en && if_a.address == 4'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    chk("A_reached_addr7", int'(found), 1);
    #2 reset_n = 1'b0;
    #1 chk_zero("A_async_rst", if_a.address, if_a.wr_en, if_a.busy, if_a.done);
    qa.delete();
    @(negedge sys_clk);
    if_a.start = 1'b1;
    reset_n    = 1'b1;
    e = cyc + 1;
    push_pass(0, e, 4, 16);
    @(negedge sys_clk);
    if_a.start = 1'b0;
    drain(100);

    // FILL_LATENCY=0, DEPTH=1.
    if_b.start = 1'b1;
    e = cyc + 1;
    push_pass(1, e, 0, 1);
    @(negedge sys_clk);
    if_b.start = 1'b0;
    drain(50);

    // DEPTH=10: pass ends at 9.
    if_c.start = 1'b1;
    e = cyc + 1;
    push_pass(2, e, 4, 10);
    @(negedge sys_clk);
    if_c.start = 1'b0;
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
